// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: branch-type encodings and
// saturating-counter initial values.
package branch_predictor_pkg;

    localparam int BRANCH_TYPE_BITS_COUNT = 4;

    typedef enum logic [BRANCH_TYPE_BITS_COUNT-1:0] {
        BT_NOT_BRANCH = 4'd0,
        BT_JAL        = 4'd1,
        BT_JALR       = 4'd2,
        BT_BEQ        = 4'd3,
        BT_BNE        = 4'd4,
        BT_BLT        = 4'd5,
        BT_BGE        = 4'd6,
        BT_BLTU       = 4'd7,
        BT_BGEU       = 4'd8
    } branch_type_e;

    // Counter values as a function of counter width.
    function automatic int unsigned cnt_weak_taken(input int unsigned cnt_bits);
        return 32'd1 << (cnt_bits - 1);
    endfunction

    function automatic int unsigned cnt_weak_not_taken(input int unsigned cnt_bits);
        return (32'd1 << (cnt_bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned cnt_strong_taken(input int unsigned cnt_bits);
        return (32'd1 << cnt_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_condition_eval.sv
// Resolves whether the executing instruction is taken from its branch kind
// and the ALU compare flags.
module branch_condition_eval
    import branch_predictor_pkg::*;
(
    input  logic [BRANCH_TYPE_BITS_COUNT-1:0] branch_type,
    input  logic                              n,
    input  logic                              z,
    input  logic                              c,
    input  logic                              v,
    output logic                              actual_taken,
    output logic                              is_branch,
    output logic                              is_jump
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        actual_taken = 1'b0;
        is_branch    = 1'b1;
        is_jump      = 1'b0;
        case (branch_type)
            BT_JAL, BT_JALR: begin
                actual_taken = 1'b1;
                is_jump      = 1'b1;
            end
            BT_BEQ:  actual_taken = z;
            BT_BNE:  actual_taken = ~z;
            BT_BLT:  actual_taken = n ^ v;
            BT_BGE:  actual_taken = ~(n ^ v);
            BT_BLTU: actual_taken = ~c;
            BT_BGEU: actual_taken = c;
            // Undefined encodings behave exactly like NOT_BRANCH.
            default: is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters,
// execute-stage resolution/mispredict detection and statistics counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int XLEN       = 32,
    parameter int CNT_BITS   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [XLEN-1:0]                   fetch_pc,
    output logic                              pred_taken,
    output logic [XLEN-1:0]                   pred_target,
    input  logic                              ex_valid,
    input  logic [XLEN-1:0]                   ex_pc,
    input  logic [BRANCH_TYPE_BITS_COUNT-1:0] ex_branch_type,
    input  logic                              ex_n,
    input  logic                              ex_z,
    input  logic                              ex_c,
    input  logic                              ex_v,
    input  logic [XLEN-1:0]                   ex_target,
    input  logic                              ex_pred_taken,
    input  logic [XLEN-1:0]                   ex_pred_target,
    output logic                              mispredict,
    output logic [XLEN-1:0]                   redirect_pc,
    output logic [31:0]                       branch_count,
    output logic [31:0]                       mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_RESET = CNT_BITS'(cnt_weak_not_taken(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_INIT  = CNT_BITS'(cnt_weak_taken(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_MAX   = CNT_BITS'(cnt_strong_taken(CNT_BITS));

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx, ex_idx;
    logic [TAG_BITS-1:0]   fetch_tag, ex_tag;
    logic                  fetch_hit, ex_hit;
    logic                  actual_taken, is_branch, is_jump;
    logic                  upd_en;

    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag = fetch_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign ex_idx    = ex_pc[INDEX_BITS+1:2];
    assign ex_tag    = ex_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign pred_taken  = fetch_hit && cnt_q[fetch_idx][CNT_BITS-1];
    assign pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);

    branch_condition_eval u_cond (
        .branch_type  (ex_branch_type),
        .n            (ex_n),
        .z            (ex_z),
        .c            (ex_c),
        .v            (ex_v),
        .actual_taken (actual_taken),
        .is_branch    (is_branch),
        .is_jump      (is_jump)
    );

    assign mispredict  = ex_valid && ((actual_taken != ex_pred_taken) ||
                                      (actual_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = actual_taken ? ex_target : ex_pc + XLEN'(4);
    assign upd_en      = ex_valid && is_branch;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q          <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_RESET;
            end
        end else begin
            if (upd_en) begin
                if (ex_hit) begin
                    if (actual_taken) begin
                        if (cnt_q[ex_idx] != CNT_MAX) cnt_q[ex_idx] <= cnt_q[ex_idx] + CNT_BITS'(1);
                    end else if (cnt_q[ex_idx] != '0) begin
                        cnt_q[ex_idx] <= cnt_q[ex_idx] - CNT_BITS'(1);
                    end
                end else if (actual_taken) begin
                    valid_q[ex_idx] <= 1'b1;
                    cnt_q[ex_idx]   <= is_jump ? CNT_MAX : CNT_INIT;
                end
                if (branch_count != '1) branch_count <= branch_count + 32'd1;
            end else if (ex_valid && ex_hit) begin
                // A non-branch sitting on a branch's entry means a stale alias.
                valid_q[ex_idx] <= 1'b0;
            end
            if (mispredict && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

    // NOTE: tag/target storage is not reset; an entry is unobservable until its valid bit is set.
    always_ff @(posedge clk) begin
        if (upd_en && actual_taken) begin
            target_q[ex_idx] <= ex_target;
            if (!ex_hit) tag_q[ex_idx] <= ex_tag;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic compared against a table-level behavioural model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int ENTRIES = 64;
    localparam int CNT_MAX = 3;

    logic        clk, rst_n;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_branch_type;
    logic        ex_n, ex_z, ex_c, ex_v;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count, mispredict_count;

    branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_branch_type   (ex_branch_type),
        .ex_n             (ex_n),
        .ex_z             (ex_z),
        .ex_c             (ex_c),
        .ex_v             (ex_v),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: one record per table slot, counters as plain integers.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int unsigned m_branches, m_mispredicts;

    logic        obs_pt, obs_mis;
    logic [31:0] obs_ptgt, obs_redir, obs_bc, obs_mc;
    logic        exp_pt, exp_mis;
    logic [31:0] exp_ptgt, exp_redir;

    function automatic int m_idx(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(logic [31:0] pc);
        return (pc >> 8) & 32'hFF;
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_is_branch(int t);
        return (t >= 1) && (t <= 8);
    endfunction

    function automatic bit m_taken(int t, bit n, bit z, bit c, bit v);
        case (t)
            1, 2:    return 1'b1;
            3:       return z;
            4:       return !z;
            5:       return n != v;
            6:       return n == v;
            7:       return !c;
            8:       return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        m_branches   = 0;
        m_mispredicts = 0;
    endtask

    task automatic set_ex(input bit v, input logic [31:0] pc, input int t, input logic [3:0] nzcv,
                          input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_branch_type = 4'(t);
        {ex_n, ex_z, ex_c, ex_v} = nzcv;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    // One clock: sample combinational outputs, advance the model, sample counters.
    task automatic step();
        bit tk;
        int i;
        #1;
        obs_pt    = pred_taken;
        obs_ptgt  = pred_target;
        obs_mis   = mispredict;
        obs_redir = redirect_pc;
        exp_pt    = m_pred(fetch_pc);
        exp_ptgt  = exp_pt ? m_target[m_idx(fetch_pc)] : fetch_pc + 32'd4;
        tk        = m_taken(int'(ex_branch_type), ex_n, ex_z, ex_c, ex_v);
        exp_mis   = ex_valid && ((tk != ex_pred_taken) || (tk && ex_target != ex_pred_target));
        exp_redir = tk ? ex_target : ex_pc + 32'd4;
        i = m_idx(ex_pc);
        if (exp_mis) m_mispredicts++;
        if (ex_valid && m_is_branch(int'(ex_branch_type))) begin
            m_branches++;
            if (m_hit(ex_pc)) begin
                m_cnt[i] = tk ? ((m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX)
                              : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
                if (tk) m_target[i] = ex_target;
            end else if (tk) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = m_tagof(ex_pc);
                m_target[i] = ex_target;
                m_cnt[i]    = (ex_branch_type inside {4'd1, 4'd2}) ? CNT_MAX : 2;
            end
        end else if (ex_valid && m_hit(ex_pc)) begin
            m_valid[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        obs_bc = branch_count;
        obs_mc = mispredict_count;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        fetch_pc = 32'h100;
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (obs_pt !== 1'b0 || obs_ptgt !== 32'h104) begin
            failures++;
            $display("FAIL reset_pred: got taken=%0b target=%h, want taken=0 target=00000104", obs_pt, obs_ptgt);
        end
        checks++;
        if (obs_bc !== 32'd0 || obs_mc !== 32'd0) begin
            failures++;
            $display("FAIL reset_counts: got branch=%0d mis=%0d, want 0 0", obs_bc, obs_mc);
        end
    endtask

    task automatic test_beq_taken();
        fetch_pc = 32'h300;
        set_ex(1'b1, 32'h100, 3, 4'b0100, 32'h80, 1'b0, 32'h104);
        step();
        checks++;
        if (obs_mis !== 1'b1 || obs_redir !== 32'h80) begin
            failures++;
            $display("FAIL beq_taken_resolve: got mis=%0b redirect=%h, want 1 00000080", obs_mis, obs_redir);
        end
        checks++;
        if (obs_bc !== 32'd1 || obs_mc !== 32'd1) begin
            failures++;
            $display("FAIL beq_taken_counts: got branch=%0d mis=%0d, want 1 1", obs_bc, obs_mc);
        end
        fetch_pc = 32'h100;
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_pt !== 1'b1 || obs_ptgt !== 32'h80) begin
            failures++;
            $display("FAIL beq_taken_predict: got taken=%0b target=%h, want 1 00000080", obs_pt, obs_ptgt);
        end
    endtask

    task automatic test_beq_not_taken();
        bit want_pt [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        fetch_pc = 32'h100;
        // Counter 10 -> 01 -> 00 -> 00, then taken once -> 01 still not taken.
        for (int k = 0; k < 4; k++) begin
            if (k < 3) set_ex(1'b1, 32'h100, 3, 4'b0000, 32'h80, want_pt[k], 32'h80);
            else       set_ex(1'b1, 32'h100, 3, 4'b0100, 32'h80, 1'b0, 32'h104);
            step();
            checks++;
            if (obs_pt !== want_pt[k] || obs_mis !== (k == 0 || k == 3)) begin
                failures++;
                $display("FAIL beq_not_taken_%0d: got pred=%0b mis=%0b, want pred=%0b mis=%0b",
                         k, obs_pt, obs_mis, want_pt[k], (k == 0 || k == 3));
            end
        end
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_pt !== 1'b0 || obs_ptgt !== 32'h104) begin
            failures++;
            $display("FAIL beq_sat_low: got taken=%0b target=%h, want 0 00000104", obs_pt, obs_ptgt);
        end
    endtask

    task automatic test_types();
        fetch_pc = 32'h600;
        set_ex(1'b1, 32'h200, 1, 4'h0, 32'h400, 1'b0, 32'h204);
        step();
        checks++;
        if (obs_mis !== 1'b1 || obs_redir !== 32'h400) begin
            failures++;
            $display("FAIL jal_resolve: got mis=%0b redirect=%h, want 1 00000400", obs_mis, obs_redir);
        end
        // One not-taken hit on a strongly-taken entry must leave it predicting taken.
        fetch_pc = 32'h200;
        set_ex(1'b1, 32'h200, 3, 4'b0000, 32'h400, 1'b1, 32'h400);
        step();
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_pt !== 1'b1 || obs_ptgt !== 32'h400) begin
            failures++;
            $display("FAIL jal_alloc_strong: got taken=%0b target=%h, want 1 00000400", obs_pt, obs_ptgt);
        end
        set_ex(1'b1, 32'h300, 7, 4'b0000, 32'h700, 1'b0, 32'h304);
        step();
        checks++;
        if (obs_mis !== 1'b1 || obs_redir !== 32'h700) begin
            failures++;
            $display("FAIL bltu_c0: got mis=%0b redirect=%h, want 1 00000700", obs_mis, obs_redir);
        end
        set_ex(1'b1, 32'h304, 8, 4'b0010, 32'h740, 1'b0, 32'h308);
        step();
        checks++;
        if (obs_mis !== 1'b1 || obs_redir !== 32'h740) begin
            failures++;
            $display("FAIL bgeu_c1: got mis=%0b redirect=%h, want 1 00000740", obs_mis, obs_redir);
        end
        set_ex(1'b1, 32'h308, 5, 4'b1001, 32'h780, 1'b0, 32'h30C);
        step();
        checks++;
        if (obs_mis !== 1'b0 || obs_redir !== 32'h30C) begin
            failures++;
            $display("FAIL blt_n1v1: got mis=%0b redirect=%h, want 0 0000030c", obs_mis, obs_redir);
        end
        set_ex(1'b1, 32'hFFFF_FFFC, 6, 4'b1000, 32'h10, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_mis !== 1'b0 || obs_redir !== 32'h0) begin
            failures++;
            $display("FAIL bge_wrap: got mis=%0b redirect=%h, want 0 00000000", obs_mis, obs_redir);
        end
    endtask

    task automatic test_alias_cleanup();
        fetch_pc = 32'h100;
        set_ex(1'b1, 32'h100, 3, 4'b0100, 32'h80, 1'b0, 32'h104);
        step();
        step();
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_pt !== 1'b1) begin
            failures++;
            $display("FAIL alias_setup: got taken=%0b, want 1", obs_pt);
        end
        set_ex(1'b1, 32'h100, 0, 4'h0, 32'h0, 1'b1, 32'h80);
        step();
        checks++;
        if (obs_mis !== 1'b1 || obs_redir !== 32'h104) begin
            failures++;
            $display("FAIL alias_resolve: got mis=%0b redirect=%h, want 1 00000104", obs_mis, obs_redir);
        end
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_pt !== 1'b0 || obs_ptgt !== 32'h104) begin
            failures++;
            $display("FAIL alias_invalidated: got taken=%0b target=%h, want 0 00000104", obs_pt, obs_ptgt);
        end
    endtask

    task automatic test_same_cycle();
        fetch_pc = 32'h140;
        set_ex(1'b1, 32'h140, 4, 4'b0000, 32'h900, 1'b0, 32'h144);
        step();
        checks++;
        if (obs_pt !== 1'b0 || obs_ptgt !== 32'h144) begin
            failures++;
            $display("FAIL same_cycle_old: got taken=%0b target=%h, want 0 00000144", obs_pt, obs_ptgt);
        end
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_pt !== 1'b1 || obs_ptgt !== 32'h900) begin
            failures++;
            $display("FAIL same_cycle_new: got taken=%0b target=%h, want 1 00000900", obs_pt, obs_ptgt);
        end
    endtask

    task automatic test_async_reset();
        fetch_pc = 32'h200;
        set_ex(1'b1, 32'h500, 2, 4'h0, 32'hA00, 1'b0, 32'h504);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h204 || branch_count !== 32'd0 ||
            mispredict_count !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: got taken=%0b target=%h branch=%0d mis=%0d, want 0 00000204 0 0",
                     pred_taken, pred_target, branch_count, mispredict_count);
        end
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'hA00) begin
            failures++;
            $display("FAIL reset_comb_resolve: got mis=%0b redirect=%h, want 1 00000a00", mispredict, redirect_pc);
        end
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        fetch_pc = 32'h500;
        set_ex(1'b0, 32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();
        checks++;
        if (obs_pt !== 1'b0 || obs_bc !== 32'd0 || obs_mc !== 32'd0) begin
            failures++;
            $display("FAIL reset_discard: got taken=%0b branch=%0d mis=%0d, want 0 0 0", obs_pt, obs_bc, obs_mc);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc_pool [8];
        logic [31:0] epc;
        for (int k = 0; k < 8; k++) begin
            // Two tags over four indices to force hits, misses and aliasing.
            pc_pool[k] = (32'(k % 2 + 1) << 8) | (32'(k / 2) << 2);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            epc = pc_pool[$urandom_range(0, 7)];
            fetch_pc = pc_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) begin
                set_ex($urandom_range(0, 3) != 0, epc, int'($urandom_range(0, 15)), 4'($urandom),
                       32'($urandom_range(0, 3)) << 12, m_pred(epc),
                       m_pred(epc) ? m_target[m_idx(epc)] : epc + 32'd4);
            end else begin
                set_ex($urandom_range(0, 3) != 0, epc, int'($urandom_range(0, 8)), 4'($urandom),
                       32'($urandom_range(0, 3)) << 12, 1'($urandom),
                       32'($urandom_range(0, 3)) << 12);
            end
            step();
            checks++;
            if (obs_pt !== exp_pt || obs_ptgt !== exp_ptgt) begin
                failures++;
                $display("FAIL rand_pred[%0d]: got %0b/%h, want %0b/%h", cyc, obs_pt, obs_ptgt, exp_pt, exp_ptgt);
            end
            checks++;
            if (obs_mis !== exp_mis || obs_redir !== exp_redir) begin
                failures++;
                $display("FAIL rand_resolve[%0d]: got %0b/%h, want %0b/%h", cyc, obs_mis, obs_redir, exp_mis, exp_redir);
            end
            checks++;
            if (obs_bc !== 32'(m_branches) || obs_mc !== 32'(m_mispredicts)) begin
                failures++;
                $display("FAIL rand_counts[%0d]: got %0d/%0d, want %0d/%0d", cyc, obs_bc, obs_mc,
                         m_branches, m_mispredicts);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_beq_not_taken();
        test_types();
        test_alias_cleanup();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
